// File: rtl/cache_line_writeback.sv
// Dirty-line eviction engine: buffers one line from data_ram and sends it as one AXI4 INCR write burst.
// Optional CACHE_WB_RETRY_EN: a non-OKAY first response triggers one resend of the buffered burst.
module cache_line_writeback #(
  parameter int TAG_WIDTH    = 20,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_req_valid,
  output logic                              o_req_ready,
  input  logic [INDEX_WIDTH-1:0]            i_req_index,
  input  logic [TAG_WIDTH-1:0]              i_req_tag,
  output logic                              o_ram_rreq,
  output logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] o_ram_raddr,
  input  logic [31:0]                       i_ram_rdata,
  output logic                              o_awvalid,
  input  logic                              i_awready,
  output logic [31:0]                       o_awaddr,
  output logic [7:0]                        o_awlen,
  output logic [2:0]                        o_awsize,
  output logic [1:0]                        o_awburst,
  output logic                              o_wvalid,
  input  logic                              i_wready,
  output logic [31:0]                       o_wdata,
  output logic [3:0]                        o_wstrb,
  output logic                              o_wlast,
  input  logic                              i_bvalid,
  output logic                              o_bready,
  input  logic [1:0]                        i_bresp,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_err
);

  localparam int N  = 1 << OFFSET_WIDTH;
  localparam int CW = OFFSET_WIDTH + 1;

  if (TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH + 2 != 32) begin : g_bad_widths
    $error("cache_line_writeback: TAG+INDEX+OFFSET+2 must equal 32");
  end

  typedef enum logic [2:0] {IDLE, READ, ADDR, DATA, RESP} state_e;

  state_e                  state_q, state_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [INDEX_WIDTH-1:0]  index_q, index_d;
  logic [CW-1:0]           rcnt_q, rcnt_d;
  logic [CW-1:0]           wcnt_q, wcnt_d;
  logic [31:0]             line_q [N];
  logic [OFFSET_WIDTH-1:0] wr_idx;
`ifdef CACHE_WB_RETRY_EN
  logic                    retry_q, retry_d;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      tag_q   <= '0;
      index_q <= '0;
      rcnt_q  <= '0;
      wcnt_q  <= '0;
`ifdef CACHE_WB_RETRY_EN
      retry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      rcnt_q  <= rcnt_d;
      wcnt_q  <= wcnt_d;
`ifdef CACHE_WB_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  // RAM data lags the address by one cycle, so the word captured now belongs to rcnt-1.
  assign wr_idx = rcnt_q[OFFSET_WIDTH-1:0] - OFFSET_WIDTH'(1);

  always_ff @(posedge i_clk) begin
    if (state_q == READ && rcnt_q != '0) begin
      line_q[wr_idx] <= i_ram_rdata;
    end
  end

  assign o_awaddr    = {tag_q, index_q, {OFFSET_WIDTH{1'b0}}, 2'b00};
  assign o_awlen     = 8'(N - 1);
  assign o_awsize    = 3'b010;
  assign o_awburst   = 2'b01;
  assign o_wdata     = line_q[wcnt_q[OFFSET_WIDTH-1:0]];
  assign o_wstrb     = 4'hF;
  assign o_ram_raddr = {index_q, rcnt_q[OFFSET_WIDTH-1:0]};
  assign o_busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    index_d     = index_q;
    rcnt_d      = rcnt_q;
    wcnt_d      = wcnt_q;
`ifdef CACHE_WB_RETRY_EN
    retry_d     = retry_q;
`endif
    o_req_ready = 1'b0;
    o_ram_rreq  = 1'b0;
    o_awvalid   = 1'b0;
    o_wvalid    = 1'b0;
    o_wlast     = 1'b0;
    o_bready    = 1'b0;
    o_done      = 1'b0;
    o_err       = 1'b0;
    case (state_q)
      IDLE: begin
        o_req_ready = i_rst_n;
        if (i_req_valid) begin
          tag_d   = i_req_tag;
          index_d = i_req_index;
          rcnt_d  = '0;
`ifdef CACHE_WB_RETRY_EN
          retry_d = 1'b0;
`endif
          state_d = READ;
        end
      end
      READ: begin
        o_ram_rreq = (rcnt_q != CW'(N));
        rcnt_d     = rcnt_q + CW'(1);
        if (rcnt_q == CW'(N)) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        o_awvalid = 1'b1;
        if (i_awready) begin
          wcnt_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        o_wvalid = 1'b1;
        o_wlast  = (wcnt_q == CW'(N - 1));
        if (i_wready) begin
          wcnt_d = wcnt_q + CW'(1);
          if (o_wlast) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        o_bready = 1'b1;
        if (i_bvalid) begin
`ifdef CACHE_WB_RETRY_EN
          // First error response earns one resend straight from the line buffer.
          if (i_bresp != 2'b00 && !retry_q) begin
            retry_d = 1'b1;
            state_d = ADDR;
          end else begin
            o_done  = 1'b1;
            o_err   = (i_bresp != 2'b00);
            state_d = IDLE;
          end
`else
          o_done  = 1'b1;
          o_err   = (i_bresp != 2'b00);
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_line_writeback.sv
// Self-checking bench for cache_line_writeback: table of writeback scenarios plus reset and back-to-back sequences.
// Expectations follow CACHE_WB_RETRY_EN when it is defined for the build.
module tb_cache_line_writeback;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [5:0]  i_req_index;
  logic [19:0] i_req_tag;
  logic        o_ram_rreq;
  logic [9:0]  o_ram_raddr;
  logic [31:0] i_ram_rdata;
  logic        o_awvalid;
  logic        i_awready;
  logic [31:0] o_awaddr;
  logic [7:0]  o_awlen;
  logic [2:0]  o_awsize;
  logic [1:0]  o_awburst;
  logic        o_wvalid;
  logic        i_wready;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstrb;
  logic        o_wlast;
  logic        i_bvalid;
  logic        o_bready;
  logic [1:0]  i_bresp;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  cache_line_writeback #(.TAG_WIDTH(20), .INDEX_WIDTH(6), .OFFSET_WIDTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_index(i_req_index), .i_req_tag(i_req_tag),
    .o_ram_rreq(o_ram_rreq), .o_ram_raddr(o_ram_raddr), .i_ram_rdata(i_ram_rdata),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
    .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata),
    .o_wstrb(o_wstrb), .o_wlast(o_wlast),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // Word k of set idx; set 5 holds 0x5000+k, other sets get a distinct upper half.
  function automatic logic [31:0] ramWord(input logic [5:0] idx, input logic [3:0] k);
    return 32'h5000 + 32'(k) + (32'(idx ^ 6'h05) << 16);
  endfunction

  // One-cycle-latency RAM; garbage when not addressed so late captures show up.
  always @(posedge i_clk) begin
    if (o_ram_rreq) i_ram_rdata <= ramWord(o_ram_raddr[9:4], o_ram_raddr[3:0]);
    else            i_ram_rdata <= 32'hDEADBEEF;
  end

  typedef struct {
    logic [19:0] tag;
    logic [5:0]  index;
    int          awDelay;
    bit          toggle;
    logic [1:0]  bresp1;
    logic [1:0]  bresp2;
    logic [31:0] expAwaddr;
    bit          expErr;
    int          expBursts;
    int          expLat;
  } vec_t;

  typedef struct {
    logic [31:0] awaddr;
    int          beats, dataErr, lastErr, awUnstable, awFieldErr;
    int          wEarly, wUnstable, latency, bursts, rreqCnt;
    bit          err;
    bit          timeout;
  } res_t;

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Runs one writeback against a scripted slave and records what the DUT did.
  task automatic applyStimulus(input vec_t v, output res_t r);
    int awWait = 0, wPhase = 0, beatIdx = 0, cyc = 0;
    bit started = 0, awDone = 0, prevStall = 0, awRefValid = 0;
    logic [31:0] prevData = '0, awRef = '0;
    r = '{default: 0};
    r.timeout = 1'b1;
    @(negedge i_clk);
    i_req_tag   = v.tag;
    i_req_index = v.index;
    i_req_valid = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (c > 0) @(negedge i_clk);
      if (started) i_req_valid = 1'b0;
      i_awready = 1'b0;
      if (o_awvalid) begin
        awWait++;
        i_awready = (awWait > v.awDelay);
      end
      i_wready = 1'b0;
      if (o_wvalid) begin
        i_wready = v.toggle ? (wPhase % 2 == 0) : 1'b1;
        wPhase++;
      end
      i_bvalid = o_bready;
      i_bresp  = (r.bursts == 0) ? v.bresp1 : v.bresp2;
      #1;
      if (!started && i_req_valid && o_req_ready) started = 1'b1;
      if (started) cyc++;
      if (o_ram_rreq) r.rreqCnt++;
      if (o_awvalid) begin
        if (!awRefValid) begin
          awRef = o_awaddr;
          awRefValid = 1'b1;
        end else if (o_awaddr !== awRef) r.awUnstable++;
      end
      if (o_wvalid && !awDone) r.wEarly++;
      if (prevStall && o_wdata !== prevData) r.wUnstable++;
      prevStall = o_wvalid && !i_wready;
      prevData  = o_wdata;
      if (o_awvalid && i_awready) begin
        r.awaddr = o_awaddr;
        awDone = 1'b1; awWait = 0; wPhase = 0; awRefValid = 1'b0;
        if (o_awlen !== 8'd15 || o_awsize !== 3'b010 || o_awburst !== 2'b01) r.awFieldErr++;
      end
      if (o_wvalid && i_wready) begin
        if (o_wdata !== ramWord(v.index, beatIdx[3:0]) || o_wstrb !== 4'hF) r.dataErr++;
        if (o_wlast !== (beatIdx == 15)) r.lastErr++;
        beatIdx++;
        r.beats++;
      end
      if (o_bready && i_bvalid) begin
        r.bursts++;
        awDone = 1'b0;
        beatIdx = 0;
      end
      if (o_done) begin
        r.err     = o_err;
        r.latency = cyc;
        r.timeout = 1'b0;
        break;
      end
    end
    @(negedge i_clk);
    i_req_valid = 1'b0; i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  vec_t vecs[6];
  res_t res;

  initial begin
    int accepts, dones, doneCyc1, acceptCyc2, doneCyc2, rreqBad, rreqCnt, beat;
    bit hit;

    vecs[0] = '{20'hABCDE, 6'h05, 0, 1'b0, 2'b00, 2'b00, 32'hABCDE140, 1'b0, 1, 36};
    vecs[1] = '{20'hABCDE, 6'h05, 0, 1'b1, 2'b00, 2'b00, 32'hABCDE140, 1'b0, 1, 51};
    vecs[2] = '{20'h12345, 6'h3F, 5, 1'b0, 2'b00, 2'b00, 32'h12345FC0, 1'b0, 1, 41};
`ifdef CACHE_WB_RETRY_EN
    vecs[3] = '{20'hABCDE, 6'h05, 0, 1'b0, 2'b10, 2'b00, 32'hABCDE140, 1'b0, 2, 54};
    vecs[4] = '{20'hABCDE, 6'h05, 0, 1'b0, 2'b10, 2'b10, 32'hABCDE140, 1'b1, 2, 54};
`else
    vecs[3] = '{20'hABCDE, 6'h05, 0, 1'b0, 2'b10, 2'b00, 32'hABCDE140, 1'b1, 1, 36};
    vecs[4] = '{20'hABCDE, 6'h05, 0, 1'b0, 2'b10, 2'b10, 32'hABCDE140, 1'b1, 1, 36};
`endif
    vecs[5] = '{20'h0F0F0, 6'h2A, 0, 1'b0, 2'b00, 2'b10, 32'h0F0F0A80, 1'b0, 1, 36};

    i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_index = '0; i_req_tag = '0;
    i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
    repeat (3) @(negedge i_clk);
    #1;
    checkOutput("reset busy",   32'(o_busy),     32'd0);
    checkOutput("reset awvalid", 32'(o_awvalid), 32'd0);
    checkOutput("reset wvalid", 32'(o_wvalid),   32'd0);
    checkOutput("reset bready", 32'(o_bready),   32'd0);
    checkOutput("reset done",   32'(o_done),     32'd0);
    checkOutput("reset rreq",   32'(o_ram_rreq), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    checkOutput("idle req_ready", 32'(o_req_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], res);
      checkOutput($sformatf("v%0d timeout", i),    32'(res.timeout),    32'd0);
      checkOutput($sformatf("v%0d awaddr", i),     res.awaddr,          vecs[i].expAwaddr);
      checkOutput($sformatf("v%0d beats", i),      32'(res.beats),      32'(16 * vecs[i].expBursts));
      checkOutput($sformatf("v%0d wdata errs", i), 32'(res.dataErr),    32'd0);
      checkOutput($sformatf("v%0d wlast errs", i), 32'(res.lastErr),    32'd0);
      checkOutput($sformatf("v%0d aw fields", i),  32'(res.awFieldErr), 32'd0);
      checkOutput($sformatf("v%0d aw stable", i),  32'(res.awUnstable), 32'd0);
      checkOutput($sformatf("v%0d w early", i),    32'(res.wEarly),     32'd0);
      checkOutput($sformatf("v%0d w stable", i),   32'(res.wUnstable),  32'd0);
      checkOutput($sformatf("v%0d latency", i),    32'(res.latency),    32'(vecs[i].expLat));
      checkOutput($sformatf("v%0d bursts", i),     32'(res.bursts),     32'(vecs[i].expBursts));
      checkOutput($sformatf("v%0d err", i),        32'(res.err),        32'(vecs[i].expErr));
      checkOutput($sformatf("v%0d rreq count", i), 32'(res.rreqCnt),    32'd16);
    end

    // Reset during beat 7 of the W phase.
    hit = 1'b0; beat = 0;
    @(negedge i_clk);
    i_req_tag = 20'hABCDE; i_req_index = 6'h05; i_req_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) @(negedge i_clk);
      if (o_busy) i_req_valid = 1'b0;
      i_awready = 1'b1; i_wready = 1'b1; i_bvalid = 1'b0;
      #1;
      if (o_wvalid && i_wready) begin
        if (beat == 7) begin
          i_rst_n = 1'b0;
          hit = 1'b1;
          break;
        end
        beat++;
      end
    end
    checkOutput("rst reached beat 7", 32'(hit), 32'd1);
    @(negedge i_clk);
    i_awready = 1'b0; i_wready = 1'b0;
    #1;
    checkOutput("rst awvalid", 32'(o_awvalid), 32'd0);
    checkOutput("rst wvalid",  32'(o_wvalid),  32'd0);
    checkOutput("rst bready",  32'(o_bready),  32'd0);
    checkOutput("rst busy",    32'(o_busy),    32'd0);
    checkOutput("rst done",    32'(o_done),    32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    #1;
    checkOutput("rst release req_ready", 32'(o_req_ready), 32'd1);

    // Request held high across two writebacks.
    accepts = 0; dones = 0; doneCyc1 = -1; acceptCyc2 = -1; doneCyc2 = -1; rreqBad = 0; rreqCnt = 0;
    @(negedge i_clk);
    i_req_tag = 20'h12345; i_req_index = 6'h3F; i_req_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) @(negedge i_clk);
      i_awready = 1'b1; i_wready = 1'b1; i_bvalid = o_bready; i_bresp = 2'b00;
      #1;
      if (o_ram_rreq) rreqCnt++;
      if (o_ram_rreq && (o_awvalid || o_wvalid || o_bready || o_req_ready)) rreqBad++;
      if (o_req_ready && i_req_valid) begin
        accepts++;
        if (accepts == 2) acceptCyc2 = c;
      end
      if (o_done) begin
        dones++;
        if (dones == 1) doneCyc1 = c;
        else begin
          doneCyc2 = c;
          i_req_valid = 1'b0;
          break;
        end
      end
    end
    @(negedge i_clk);
    i_req_valid = 1'b0; i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0;
    checkOutput("b2b accepts",        32'(accepts),             32'd2);
    checkOutput("b2b dones",          32'(dones),               32'd2);
    checkOutput("b2b accept after done", 32'(acceptCyc2 - doneCyc1), 32'd1);
    checkOutput("b2b second latency", 32'(doneCyc2 - acceptCyc2 + 1), 32'd36);
    checkOutput("b2b rreq outside READ", 32'(rreqBad),      32'd0);
    checkOutput("b2b rreq count",     32'(rreqCnt),             32'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
